// File: rtl/regfile_pkg.sv
// Shared defaults and address qualification for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int LED_REG_DEF    = 31;
  localparam int LED_WIDTH_DEF  = 16;

  // A register address is usable for write, reserve or read when nonzero and in range.
  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned num_regs);
    return (addr != 32'd0) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port with optional write-to-read forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW     = DATA_WIDTH_DEF,
  parameter int AW     = ADDR_WIDTH_DEF,
  parameter int NR     = NUM_REGS_DEF,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_regs [NR],
  input  logic [NR-1:0] i_pending,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd_a,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_wb,
  input  logic [DW-1:0] i_wd_b,
  input  logic          i_reserve,
  input  logic [AW-1:0] i_reserve_reg,
  output logic [DW-1:0] o_data,
  output logic          o_pending
);

  logic w_rd_valid;
  logic w_hit_a;
  logic w_hit_b;
  logic w_rsv_hit;

  assign w_rd_valid = addr_valid(32'(i_addr), NR);
  assign w_hit_a    = (BYPASS != 0) && i_we_a && addr_valid(32'(i_wa), NR) && (i_wa == i_addr);
  assign w_hit_b    = (BYPASS != 0) && i_we_b && addr_valid(32'(i_wb), NR) && (i_wb == i_addr);
  assign w_rsv_hit  = i_reserve && addr_valid(32'(i_reserve_reg), NR) && (i_reserve_reg == i_addr);

  // A forwarded result is only still pending if the same cycle re-reserves it.
  always_comb begin
    o_data    = '0;
    o_pending = 1'b0;
    if (w_rd_valid) begin
      if (w_hit_a) begin
        o_data    = i_wd_a;
        o_pending = w_rsv_hit;
      end else if (w_hit_b) begin
        o_data    = i_wd_b;
        o_pending = w_rsv_hit;
      end else begin
        o_data    = i_regs[i_addr];
        o_pending = i_pending[i_addr];
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write-port register file with per-register pending bits, double-reserve flag and LED mirror.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int LED_REG    = LED_REG_DEF,
  parameter int LED_WIDTH  = LED_WIDTH_DEF
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           ctrl_writeEnableA,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeRegA,
  input  logic [DATA_WIDTH-1:0]          data_writeRegA,
  input  logic                           ctrl_writeEnableB,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeRegB,
  input  logic [DATA_WIDTH-1:0]          data_writeRegB,
  input  logic                           ctrl_reserve,
  input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            read_pending,
  output logic                           err_double_reserve,
  output logic [LED_WIDTH-1:0]           led_output
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pending;
  logic                  r_err;
  logic [LED_WIDTH-1:0]  r_led;

  logic                  w_we_a;
  logic                  w_we_b;
  logic                  w_rsv;
  logic                  w_wa_eff;
  logic                  w_wb_eff;
  logic                  w_rsv_eff;
  logic                  w_double;
  logic [NUM_REGS-1:0]   w_pending_nxt;

  // Gating with reset keeps forwarded data from leaking onto the read ports during reset.
  assign w_we_a    = ctrl_writeEnableA & ctrl_reset_n;
  assign w_we_b    = ctrl_writeEnableB & ctrl_reset_n;
  assign w_rsv     = ctrl_reserve & ctrl_reset_n;

  assign w_wa_eff  = w_we_a && addr_valid(32'(ctrl_writeRegA), NUM_REGS);
  assign w_wb_eff  = w_we_b && addr_valid(32'(ctrl_writeRegB), NUM_REGS);
  assign w_rsv_eff = w_rsv  && addr_valid(32'(ctrl_reserveReg), NUM_REGS);

  assign w_double  = w_rsv_eff && r_pending[ctrl_reserveReg]
                     && !(w_wa_eff && (ctrl_writeRegA == ctrl_reserveReg))
                     && !(w_wb_eff && (ctrl_writeRegB == ctrl_reserveReg));

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wa_eff)  w_pending_nxt[ctrl_writeRegA]  = 1'b0;
    if (w_wb_eff)  w_pending_nxt[ctrl_writeRegB]  = 1'b0;
    if (w_rsv_eff) w_pending_nxt[ctrl_reserveReg] = 1'b1;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
      r_led     <= '0;
    end else begin
      // A is assigned last so it wins a same-register collision with B.
      if (w_wb_eff) r_regs[ctrl_writeRegB] <= data_writeRegB;
      if (w_wa_eff) r_regs[ctrl_writeRegA] <= data_writeRegA;
      r_pending <= w_pending_nxt;
      if (w_double) r_err <= 1'b1;
      if (w_wa_eff && (ctrl_writeRegA == ADDR_WIDTH'(LED_REG)))
        r_led <= data_writeRegA[LED_WIDTH-1:0];
      else if (w_wb_eff && (ctrl_writeRegB == ADDR_WIDTH'(LED_REG)))
        r_led <= data_writeRegB[LED_WIDTH-1:0];
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    regfile_read_port #(
      .DW     (DATA_WIDTH),
      .AW     (ADDR_WIDTH),
      .NR     (NUM_REGS),
      .BYPASS (BYPASS)
    ) u_rd (
      .i_addr        (ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_regs        (r_regs),
      .i_pending     (r_pending),
      .i_we_a        (w_we_a),
      .i_wa          (ctrl_writeRegA),
      .i_wd_a        (data_writeRegA),
      .i_we_b        (w_we_b),
      .i_wb          (ctrl_writeRegB),
      .i_wd_b        (data_writeRegB),
      .i_reserve     (w_rsv),
      .i_reserve_reg (ctrl_reserveReg),
      .o_data        (data_readReg[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_pending     (read_pending[k])
    );
  end

  assign err_double_reserve = r_err;
  assign led_output         = r_led;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench: a bypassing and a non-bypassing instance share one stimulus stream.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic              clock = 1'b0;
  logic              ctrl_reset_n;
  logic              ctrl_writeEnableA;
  logic [AW-1:0]     ctrl_writeRegA;
  logic [DW-1:0]     data_writeRegA;
  logic              ctrl_writeEnableB;
  logic [AW-1:0]     ctrl_writeRegB;
  logic [DW-1:0]     data_writeRegB;
  logic              ctrl_reserve;
  logic [AW-1:0]     ctrl_reserveReg;
  logic [NRD*AW-1:0] ctrl_readReg;

  logic [NRD*DW-1:0] data_readReg, nb_data_readReg;
  logic [NRD-1:0]    read_pending, nb_read_pending;
  logic              err_double_reserve, nb_err_double_reserve;
  logic [15:0]       led_output, nb_led_output;

  always #5 clock = ~clock;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnableA(ctrl_writeEnableA), .ctrl_writeRegA(ctrl_writeRegA), .data_writeRegA(data_writeRegA),
    .ctrl_writeEnableB(ctrl_writeEnableB), .ctrl_writeRegB(ctrl_writeRegB), .data_writeRegB(data_writeRegB),
    .ctrl_reserve(ctrl_reserve), .ctrl_reserveReg(ctrl_reserveReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(data_readReg), .read_pending(read_pending),
    .err_double_reserve(err_double_reserve), .led_output(led_output));

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnableA(ctrl_writeEnableA), .ctrl_writeRegA(ctrl_writeRegA), .data_writeRegA(data_writeRegA),
    .ctrl_writeEnableB(ctrl_writeEnableB), .ctrl_writeRegB(ctrl_writeRegB), .data_writeRegB(data_writeRegB),
    .ctrl_reserve(ctrl_reserve), .ctrl_reserveReg(ctrl_reserveReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(nb_data_readReg), .read_pending(nb_read_pending),
    .err_double_reserve(nb_err_double_reserve), .led_output(nb_led_output));

  // kind: 0 data, 1 pending, 2 err, 3 led (BYPASS=1); 4 data, 5 pending (BYPASS=0)
  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      0: return data_readReg[idx*DW +: DW];
      1: return 32'(read_pending[idx]);
      2: return 32'(err_double_reserve);
      3: return 32'(led_output);
      4: return nb_data_readReg[idx*DW +: DW];
      5: return 32'(nb_read_pending[idx]);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        a = actual(e.kind, e.idx);
        n_vec++;
        if (e.cyc != cyc || a !== e.val) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h (due cycle %0d)",
                   e.name, cyc, a, e.val, e.cyc);
        end
      end
    end
  end

  task automatic expect_v(input int kind, input int idx, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ctrl_writeEnableA = 1'b0;
    ctrl_writeEnableB = 1'b0;
    ctrl_reserve      = 1'b0;
  endtask

  task automatic wr_a(input int r, input logic [31:0] d);
    ctrl_writeEnableA = 1'b1; ctrl_writeRegA = AW'(r); data_writeRegA = d;
  endtask

  task automatic wr_b(input int r, input logic [31:0] d);
    ctrl_writeEnableB = 1'b1; ctrl_writeRegB = AW'(r); data_writeRegB = d;
  endtask

  task automatic rsv(input int r);
    ctrl_reserve = 1'b1; ctrl_reserveReg = AW'(r);
  endtask

  task automatic rd(input int p, input int r);
    ctrl_readReg[p*AW +: AW] = AW'(r);
  endtask

  initial begin : stim
    ctrl_reset_n = 1'b0;
    ctrl_writeEnableA = 1'b0; ctrl_writeRegA = '0; data_writeRegA = '0;
    ctrl_writeEnableB = 1'b0; ctrl_writeRegB = '0; data_writeRegB = '0;
    ctrl_reserve = 1'b0; ctrl_reserveReg = '0; ctrl_readReg = '0;

    step();
    rd(0, 5); rd(1, 31);
    expect_v(0, 0, 32'h0, "rst_data0"); expect_v(1, 0, 32'h0, "rst_pend0");
    expect_v(0, 1, 32'h0, "rst_data1"); expect_v(2, 0, 32'h0, "rst_err");
    expect_v(3, 0, 32'h0, "rst_led");

    step(); ctrl_reset_n = 1'b1;
    wr_a(5, 32'hDEADBEEF); rd(0, 5);
    expect_v(0, 0, 32'hDEADBEEF, "bypass_r5"); expect_v(4, 0, 32'h0, "nb_old_r5");

    step(); wr_a(0, 32'h1234); rd(0, 5); rd(1, 0);
    expect_v(0, 0, 32'hDEADBEEF, "read_r5"); expect_v(1, 0, 32'h0, "pend_r5");
    expect_v(4, 0, 32'hDEADBEEF, "nb_read_r5"); expect_v(0, 1, 32'h0, "r0_bypass");

    step(); rd(1, 0);
    expect_v(0, 1, 32'h0, "r0_zero"); expect_v(1, 1, 32'h0, "r0_pend");

    step(); rsv(7); rd(0, 7);
    step(); step(); step();
    expect_v(1, 0, 32'h1, "pend_r7"); expect_v(5, 0, 32'h1, "nb_pend_r7");

    step(); wr_b(7, 32'h00000042);
    expect_v(0, 0, 32'h42, "byp_r7_data"); expect_v(1, 0, 32'h0, "byp_r7_pend");
    expect_v(4, 0, 32'h0, "nb_r7_data"); expect_v(5, 0, 32'h1, "nb_r7_pend");

    step();
    expect_v(0, 0, 32'h42, "r7_data"); expect_v(1, 0, 32'h0, "r7_pend_clr");
    expect_v(5, 0, 32'h0, "nb_r7_pend_clr");

    step(); wr_a(9, 32'h11111111); wr_b(9, 32'h22222222);
    step(); rd(1, 9);
    expect_v(0, 1, 32'h11111111, "ab_collide"); expect_v(4, 1, 32'h11111111, "nb_ab_collide");

    step(); rsv(3);
    step(); rsv(3);
    expect_v(2, 0, 32'h0, "err_before");
    step(); rsv(4); wr_b(4, 32'hCAFE0004); rd(0, 4);
    expect_v(2, 0, 32'h1, "err_set");
    expect_v(0, 0, 32'hCAFE0004, "rsv_wr_byp_data"); expect_v(1, 0, 32'h1, "rsv_wr_byp_pend");
    step(); rd(1, 3);
    expect_v(0, 0, 32'hCAFE0004, "r4_data"); expect_v(1, 0, 32'h1, "r4_pend");
    expect_v(1, 1, 32'h1, "r3_pend"); expect_v(2, 0, 32'h1, "err_sticky");

    step(); wr_a(31, 32'hABCD5678);
    expect_v(3, 0, 32'h0, "led_not_yet");
    step(); wr_a(30, 32'h1111FFFF);
    expect_v(3, 0, 32'h5678, "led_load");
    step(); rd(1, 30);
    expect_v(3, 0, 32'h5678, "led_hold"); expect_v(0, 1, 32'h1111FFFF, "r30");
    expect_v(2, 0, 32'h1, "err_still");

    step(); ctrl_reset_n = 1'b0; wr_a(12, 32'h77); rd(0, 12); rd(1, 5);
    expect_v(0, 0, 32'h0, "rst_mid_byp"); expect_v(0, 1, 32'h0, "rst_mid_r5");
    expect_v(1, 1, 32'h0, "rst_mid_pend"); expect_v(2, 0, 32'h0, "rst_mid_err");
    expect_v(3, 0, 32'h0, "rst_mid_led"); expect_v(4, 1, 32'h0, "nb_rst_mid_r5");

    step(); ctrl_reset_n = 1'b1;
    expect_v(0, 0, 32'h0, "no_commit_r12"); expect_v(4, 0, 32'h0, "nb_no_commit_r12");
    expect_v(1, 0, 32'h0, "r12_pend");

    step(); wr_a(12, 32'h99);
    expect_v(0, 0, 32'h99, "byp_r12"); expect_v(4, 0, 32'h0, "nb_old_r12");
    step();
    expect_v(0, 0, 32'h99, "r12"); expect_v(4, 0, 32'h99, "nb_r12");

    step(); step();
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the processor register file. It provides configurable width, depth and read-port count, and two write ports: port A for in-order writeback and port B for FFT-unit/multicycle writeback. It adds per-register pending (scoreboard) bits for outstanding long-latency results, optional write-to-read bypass, and a registered LED mirror of one register. It sits between decode/issue (reserve, reads) and writeback (writes) in the CPU datapath.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, register count; register 0 hardwired zero
ADDR_WIDTH, 5, register address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS
NUM_READ, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return pre-write contents
LED_REG, 31, register mirrored to led_output
LED_WIDTH, 16, low bits of LED_REG driven to LEDs

Ports:
clock  in  1  single clock; all state updates on its rising edge
ctrl_reset_n  in  1  asynchronous, active-low reset
ctrl_writeEnableA  in  1  write port A enable
ctrl_writeRegA  in  ADDR_WIDTH  write port A address
data_writeRegA  in  DATA_WIDTH  write port A data
ctrl_writeEnableB  in  1  write port B enable
ctrl_writeRegB  in  ADDR_WIDTH  write port B address
data_writeRegB  in  DATA_WIDTH  write port B data
ctrl_reserve  in  1  mark destination register pending
ctrl_reserveReg  in  ADDR_WIDTH  register to reserve
ctrl_readReg  in  NUM_READ*ADDR_WIDTH  read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
data_readReg  out  NUM_READ*DATA_WIDTH  read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
read_pending  out  NUM_READ  1 = port k's register awaits an outstanding result
err_double_reserve  out  1  sticky: a reserve targeted an already-pending register
led_output  out  LED_WIDTH  registered mirror of LED_REG[LED_WIDTH-1:0]

Behaviour:
- Reset (ctrl_reset_n=0, asynchronous): all registers 0, all pending bits 0, err_double_reserve 0, led_output 0. Reset asserted mid-operation discards any in-flight write or reserve.
- Effective write: enable=1, address nonzero, address < NUM_REGS. Writes that fail this test are ignored and have no side effects.
- Writes commit at the rising edge. If A and B target the same register in one cycle, A's data is stored and B is dropped; both writes still count as clearing pending.
- Register 0 always reads 0, is never pending, and is never reserved.
- Reads with address >= NUM_REGS return 0 with pending=0.
- Reserve (effective under the same address rules as writes) sets pending[r] at the edge.
- Pending clears on an effective write to r, unless the same cycle also reserves r; in that case pending stays 1 and the data is updated.
- Reserving a register that is already pending (and not written that cycle) sets err_double_reserve. The register stays pending. The flag clears only on reset.
- Reads are combinational, with zero latency from address to data.
  - BYPASS=1: if an effective write targets the read address in the same cycle, the read returns the write data (A wins over B) and read_pending=0, unless the same cycle also reserves that register.
  - BYPASS=1, no matching write, or BYPASS=0: the read returns the stored value and read_pending equals the stored pending bit.
- LED: led_output loads the low LED_WIDTH bits of the winning data on an effective write to LED_REG, and holds otherwise. It is updated 1 cycle after the write; the output is not zeroed between writes.
- Unconnected/X addresses are not handled; the bench drives all inputs.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_WIDTH/NUM_REGS/ADDR_WIDTH constants
  - LED_REG and LED_WIDTH defaults
  - an addr_valid function (nonzero, < NUM_REGS) shared by write, reserve and read logic.
- Sub-module regfile_read_port, one instance per read port (generate loop). Inputs: address, array slice, pending vector, both write ports, reserve. Outputs: data and pending, with the bypass mux.
- Top level holds the storage array, pending vector, error flag and LED register.

Test Plan:
1. Reset, then write A r5=0xDEADBEEF. Next cycle read r5 → 0xDEADBEEF with pending=0. Write r0=0x1234 → r0 still reads 0.
2. Reserve r7, then wait 3 cycles: read_pending for r7 = 1. Write B r7=0x00000042: same cycle with BYPASS=1, read → 0x42 with pending=0. Next cycle pending=0.
3. Same cycle, A writes r9=0x11111111 and B writes r9=0x22222222 → r9 reads 0x11111111.
4. Reserve r3, then reserve r3 again → err_double_reserve=1 and stays 1 until reset. Reserve r4 with a B write to r4 in the same cycle → r4 stays pending and holds the new data.
5. Write r31=0xABCD5678 → led_output=0x5678 one cycle later. Write r30 → led_output holds 0x5678.
6. Assert ctrl_reset_n low mid-cycle while a write is enabled → all outputs 0 immediately, and the write is not committed after release. Repeat with BYPASS=0: a same-cycle read returns the old value.
